// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC sequencing plus the IF/ID pipeline register.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_err and traps misaligned branch targets.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [31:0] inst_i,
  output logic        ce,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_d;
  logic        br_take;
  logic        br_misal;

  // A branch is only honoured once fetch is running and nothing outranks it.
  assign br_take = ce && !flush && !stall_if && branch_flag;

`ifdef FETCH_ALIGN_CHECK_EN
  assign br_misal = br_take && (branch_target[1:0] != 2'b00);
`else
  assign br_misal = 1'b0;
`endif

  always_comb begin
    pc_d = pc + 32'd4;
    if (!ce)                        pc_d = RESET_PC;
    else if (flush)                 pc_d = new_pc & ALIGN_MASK;
    else if (stall_if)              pc_d = pc;
    else if (br_take && !br_misal)  pc_d = branch_target & ALIGN_MASK;
  end

  // Bubbles zero the whole IF/ID entry; a stalled decode keeps its entry.
  always_comb begin
    ifid_d = ifid_q;
    if (flush || br_misal || (stall_if && !stall_id)) begin
      ifid_d = '0;
    end else if (!stall_if) begin
      ifid_d.pc   = pc;
      ifid_d.inst = ce ? inst_i : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce     <= 1'b0;
      pc     <= RESET_PC;
      ifid_q <= '0;
    end else begin
      ce     <= 1'b1;
      pc     <= pc_d;
      ifid_q <= ifid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_err <= 1'b0;
    else      fetch_err <= br_misal;
  end
`endif

  assign id_pc   = ifid_q.pc;
  assign id_inst = ifid_q.inst;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized scoreboard bench for pc_fetch: a reference model pushes expected
// state per edge, an independent monitor pops and compares after each edge.
module tb_pc_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0, stall_id = 1'b0, branch_flag = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0, new_pc = '0;
  logic [31:0] inst_i;
  logic        ce;
  logic [31:0] pc, id_pc, id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc), .inst_i(inst_i),
    .ce(ce), .pc(pc), .id_pc(id_pc), .id_inst(id_inst)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_err(fetch_err)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed, address-dependent word pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[31:16]};
  endfunction
  assign inst_i = mem_word(pc);

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the fetch stage should hold after each edge.
  bit          m_ce = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_id_pc = '0, m_id_inst = '0;
  bit          m_err = 1'b0;

  task automatic model_edge();
    bit          taken, misal;
    logic [31:0] nxt;
    taken = m_ce && !flush && !stall_if && branch_flag;
    misal = ALIGN_CHK && taken && (branch_target % 4 != 0);
    if (!m_ce)                nxt = RESET_PC;
    else if (flush)           nxt = new_pc - (new_pc % 4);
    else if (stall_if)        nxt = m_pc;
    else if (taken && !misal) nxt = branch_target - (branch_target % 4);
    else                      nxt = m_pc + 4;
    if (flush || misal || (stall_if && !stall_id)) begin
      m_id_pc = 0; m_id_inst = 0;
    end else if (!stall_if) begin
      m_id_pc   = m_pc;
      m_id_inst = m_ce ? mem_word(m_pc) : 32'h0;
    end
    m_pc  = nxt;
    m_ce  = 1'b1;
    m_err = misal;
    sb.push_back('{m_ce, m_pc, m_id_pc, m_id_inst, m_err});
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_ce = 0; m_pc = RESET_PC; m_id_pc = 0; m_id_inst = 0; m_err = 0;
      end else begin
        model_edge();
      end
    end
  end

  // Monitor: compares every expected entry after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ce", 32'(ce), 32'(e.ce));
        chk("pc", pc, e.pc);
        chk("id_pc", id_pc, e.id_pc);
        chk("id_inst", id_inst, e.id_inst);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("fetch_err", 32'(fetch_err), 32'(e.err));
`endif
      end
    end
  end

  task automatic drive(input bit si, input bit sd, input bit bf, input logic [31:0] bt,
                       input bit fl, input logic [31:0] np);
    @(negedge clk);
    stall_if = si; stall_id = sd; branch_flag = bf; branch_target = bt;
    flush = fl; new_pc = np;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(3))
      0:       return 32'($urandom_range(255));
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(99) < 20, 1'($urandom_range(1)), $urandom_range(99) < 15,
            rand_tgt(), $urandom_range(99) < 4, rand_tgt());
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ce"}, 32'(ce), 32'h0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_id_inst"}, id_inst, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'h0);
`endif
  endtask

  initial begin
    #2;
    reset_checks("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Reset release and sequential fetch to 0x10.
    idle(4);
    // Two-cycle IF stall with decode free: bubbles, then resume.
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    idle(1);
    // Branch to 0x40, then a branch held off by an IF stall.
    drive(0, 0, 1, 32'h40, 0, 32'h0);
    drive(1, 1, 1, 32'h80, 0, 32'h0);
    drive(1, 0, 1, 32'h80, 0, 32'h0);
    idle(1);
    // Flush beats stall and branch together.
    drive(1, 0, 1, 32'h40, 1, 32'h380);
    idle(2);
    // Flush vector with low bits set, near the top of the address space.
    drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFB);
    idle(3);
    // Misaligned branch target.
    drive(0, 0, 1, 32'h42, 0, 32'h0);
    idle(2);
    // Decode stall with fetch stall: IF/ID holds.
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 32'h0);
    idle(1);
    random_phase(1500);
    // Asynchronous reset mid-stall and mid-redirect.
    @(negedge clk);
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h1234; flush = 1'b1; new_pc = 32'h500;
    #2;
    rst = 1'b0;
    #1;
    reset_checks("mid");
    @(negedge clk);
    @(negedge clk);
    stall_if = 0; branch_flag = 0; flush = 0;
    rst = 1'b1;
    idle(3);
    random_phase(800);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL provide port stall_if, input, 1 bit: hold PC and do not advance the fetch.
REQ-005 SHALL provide port stall_id, input, 1 bit: hold the IF/ID register.
REQ-006 SHALL provide port branch_flag, input, 1 bit: redirect request from decode.
REQ-007 SHALL provide port branch_target, input, 32 bits: redirect address.
REQ-008 SHALL provide port flush, input, 1 bit: exception or pipeline flush.
REQ-009 SHALL provide port new_pc, input, 32 bits: flush vector.
REQ-010 SHALL provide port inst_i, input, 32 bits: instruction word returned combinationally by instruction memory for pc.
REQ-011 SHALL provide port ce, output, 1 bit: instruction memory enable (registered).
REQ-012 SHALL provide port pc, output, 32 bits: fetch byte address to instruction memory (registered).
REQ-013 SHALL provide port id_pc, output, 32 bits: IF/ID latched PC.
REQ-014 SHALL provide port id_inst, output, 32 bits: IF/ID latched instruction.
REQ-015 SHALL provide port fetch_err, output, 1 bit: misaligned-redirect flag; present only under the configuration macro.

Function
REQ-016 ce SHALL rise to 1 on the first clk edge after rst deasserts and SHALL then stay 1.
REQ-017 While ce=0 at an edge, pc SHALL load RESET_PC, so the first fetched word is at RESET_PC.
REQ-018 With ce=1, the next-pc priority SHALL be: flush -> new_pc; else stall_if=1 -> hold; else branch_flag=1 -> branch_target; else pc+4.
REQ-019 pc+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC is followed by 32'h00000000.
REQ-020 All redirect addresses SHALL have bits [1:0] forced to 2'b00 before loading pc.
REQ-021 The IF/ID register priority SHALL be: flush -> id_pc=0 and id_inst=0; else stall_if=1 and stall_id=0 -> bubble (0, 0); else stall_if=0 -> capture pc and inst_i; else hold.
REQ-022 When ce=0, the value captured into id_inst SHALL be 32'h00000000.
REQ-023 branch_flag asserted during stall_if=1 SHALL be ignored; decode re-asserts it until it is taken.
REQ-024 Latency SHALL be: pc at edge N, instruction visible on id_inst after edge N+1; throughput one instruction per cycle when unstalled.
REQ-025 Simultaneous flush and branch_flag SHALL resolve to flush.

Reset
REQ-026 Asserting rst at any time, including mid-stall or mid-redirect, SHALL immediately force ce=0, pc=RESET_PC, id_pc=0, id_inst=0 and fetch_err=0.
REQ-027 No state SHALL survive reset.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN SHALL select misaligned-redirect handling.
REQ-029 With FETCH_ALIGN_CHECK_EN defined, a taken branch whose target has bits [1:0] nonzero SHALL pulse fetch_err for one cycle, leave pc at pc+4, and bubble IF/ID that cycle.
REQ-030 With FETCH_ALIGN_CHECK_EN undefined, the fetch_err port SHALL be absent and REQ-020 silent alignment SHALL apply.

Verification
REQ-031 Reset release with RESET_PC=0 -> ce=1 after edge 1; pc=0, 4, 8 on successive edges; id_pc lags pc by one cycle.
REQ-032 stall_if=1 and stall_id=0 for 2 cycles at pc=0x10 -> pc holds 0x10; id_inst=0 for 2 cycles; resumes at 0x14.
REQ-033 branch_flag=1 with target 0x40 at pc=0x8 -> next pc=0x40; branch_flag during stall_if=1 -> no redirect.
REQ-034 flush=1, new_pc=0x380, branch_flag=1 and stall_if=1 together -> pc=0x380; id_pc=0 and id_inst=0.
REQ-035 pc=0xFFFFFFFC unstalled -> next pc=0x00000000.
REQ-036 Macro defined, branch target 0x42 -> fetch_err pulses for 1 cycle, no redirect; macro undefined -> pc=0x40.
